// File: rtl/hub75_scan_driver.sv
// HUB75 1/16-scan driver: reads RGB565 pixel pairs from the frame RAM and shows them as BCM bit-planes.
// Colour bits reach the pins one cycle after their address; there is no backpressure, the panel timing is free-running.
module hub75_scan_driver #(
   parameter int BPP        = 5,
   parameter int BASE_TICKS = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   output logic [9:0]  read_addr,
   output logic        read_en,
   input  logic [15:0] read_data_top,
   input  logic [15:0] read_data_bottom,
   output logic        hub75_clk,
   output logic        hub75_lat,
   output logic        hub75_oe_n,
   output logic [3:0]  hub75_addr,
   output logic        hub75_r1,
   output logic        hub75_g1,
   output logic        hub75_b1,
   output logic        hub75_r2,
   output logic        hub75_g2,
   output logic        hub75_b2,
   output logic        frame_done
);

   localparam int         MAX_TICKS  = BASE_TICKS << (BPP - 1);
   localparam int         CNT_W      = $clog2(MAX_TICKS + 1);
   localparam logic [2:0] LAST_PLANE = 3'(BPP - 1);
   localparam logic [2:0] K_OFFSET   = 3'(5 - BPP);

   typedef enum logic [2:0] {
      IDLE,
      PREFETCH,
      SHIFT_LO,
      SHIFT_HI,
      BLANK,
      LATCH,
      DISPLAY
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [3:0]       row;
   logic [2:0]       plane;
   logic [5:0]       col;
   logic [CNT_W-1:0] disp_cnt;
   logic             disp_done;
   logic             last_col;
   logic             enter_lo;
   logic [2:0]       kidx;
   logic [4:0]       top_r;
   logic [4:0]       top_g;
   logic [4:0]       top_b;
   logic [4:0]       bot_r;
   logic [4:0]       bot_g;
   logic [4:0]       bot_b;
   logic             unused_green_lsb;

   assign disp_done = (disp_cnt == '0);
   assign last_col  = (col == 6'd63);
   assign enter_lo  = (state_nxt == SHIFT_LO);
   assign kidx      = plane + K_OFFSET;

   // Green is 6 bits wide; its LSB never reaches a displayed plane.
   assign top_r = read_data_top[15:11];
   assign top_g = read_data_top[10:6];
   assign top_b = read_data_top[4:0];
   assign bot_r = read_data_bottom[15:11];
   assign bot_g = read_data_bottom[10:6];
   assign bot_b = read_data_bottom[4:0];
   assign unused_green_lsb = read_data_top[5] ^ read_data_bottom[5];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (enable) state_nxt = PREFETCH;
         PREFETCH: state_nxt = SHIFT_LO;
         SHIFT_LO: state_nxt = SHIFT_HI;
         SHIFT_HI: state_nxt = last_col ? BLANK : SHIFT_LO;
         BLANK:    state_nxt = LATCH;
         LATCH:    state_nxt = DISPLAY;
         DISPLAY:  if (disp_done) state_nxt = enable ? PREFETCH : IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // The address runs one column ahead of the column on the pins and parks on 63.
   always_comb begin
      read_en    = 1'b0;
      read_addr  = '0;
      hub75_clk  = 1'b0;
      hub75_lat  = 1'b0;
      hub75_oe_n = 1'b1;
      case (state)
         PREFETCH: begin
            read_en   = 1'b1;
            read_addr = {row, 6'd0};
         end
         SHIFT_LO: begin
            read_en   = 1'b1;
            read_addr = {row, last_col ? 6'd63 : col + 6'd1};
         end
         SHIFT_HI: begin
            read_en   = 1'b1;
            read_addr = {row, last_col ? 6'd63 : col + 6'd1};
            hub75_clk = 1'b1;
         end
         LATCH:   hub75_lat  = 1'b1;
         DISPLAY: hub75_oe_n = 1'b0;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         row        <= '0;
         plane      <= '0;
         col        <= '0;
         disp_cnt   <= '0;
         hub75_addr <= '0;
         hub75_r1   <= 1'b0;
         hub75_g1   <= 1'b0;
         hub75_b1   <= 1'b0;
         hub75_r2   <= 1'b0;
         hub75_g2   <= 1'b0;
         hub75_b2   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               row   <= '0;
               plane <= '0;
               col   <= '0;
            end
            PREFETCH: col <= '0;
            SHIFT_HI: col <= col + 6'd1;
            LATCH:    disp_cnt <= CNT_W'((BASE_TICKS << plane) - 1);
            DISPLAY: begin
               if (disp_done) begin
                  if (plane != LAST_PLANE) begin
                     plane <= plane + 3'd1;
                  end else begin
                     plane      <= '0;
                     row        <= row + 4'd1;
                     frame_done <= (row == 4'd15);
                  end
                  // An abort always restarts the next scan from the top of the frame.
                  if (!enable) begin
                     row   <= '0;
                     plane <= '0;
                  end
               end else begin
                  disp_cnt <= disp_cnt - 1'b1;
               end
            end
            default: ;
         endcase

         if (state_nxt == BLANK) begin
            hub75_addr <= row;
         end

         if (enter_lo) begin
            hub75_r1 <= top_r[kidx];
            hub75_g1 <= top_g[kidx];
            hub75_b1 <= top_b[kidx];
            hub75_r2 <= bot_r[kidx];
            hub75_g2 <= bot_g[kidx];
            hub75_b2 <= bot_b[kidx];
         end
      end
   end

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Directed bench for hub75_scan_driver: a 5-plane instance with constant RAM data and a 1-plane instance with a single lit pixel.
module tb_hub75_scan_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Instance A: BPP=5, BASE_TICKS=8
   logic        a_rst_n;
   logic        a_en;
   logic [9:0]  a_ra;
   logic        a_re;
   logic [15:0] a_top;
   logic [15:0] a_bot;
   logic        a_clk;
   logic        a_lat;
   logic        a_oe_n;
   logic [3:0]  a_addr;
   logic        a_r1, a_g1, a_b1, a_r2, a_g2, a_b2;
   logic        a_fd;

   assign a_top = 16'hF800;
   assign a_bot = 16'h001F;

   hub75_scan_driver #(.BPP(5), .BASE_TICKS(8)) dut (
      .clk(clk), .reset_n(a_rst_n), .enable(a_en),
      .read_addr(a_ra), .read_en(a_re),
      .read_data_top(a_top), .read_data_bottom(a_bot),
      .hub75_clk(a_clk), .hub75_lat(a_lat), .hub75_oe_n(a_oe_n), .hub75_addr(a_addr),
      .hub75_r1(a_r1), .hub75_g1(a_g1), .hub75_b1(a_b1),
      .hub75_r2(a_r2), .hub75_g2(a_g2), .hub75_b2(a_b2),
      .frame_done(a_fd)
   );

   // Instance B: BPP=1, one lit pixel at {row 3, col 5} in the top half
   logic        b_rst_n;
   logic        b_en;
   logic [9:0]  b_ra;
   logic        b_re;
   logic [15:0] b_top;
   logic [15:0] b_bot;
   logic        b_clk;
   logic        b_lat;
   logic        b_oe_n;
   logic [3:0]  b_addr;
   logic        b_r1, b_g1, b_b1, b_r2, b_g2, b_b2;
   logic        b_fd;

   // Data for an address is sampled by the driver on the clock after that address is presented.
   assign b_top = (b_ra == {4'd3, 6'd5}) ? 16'h8410 : 16'h0000;
   assign b_bot = 16'h0000;

   hub75_scan_driver #(.BPP(1), .BASE_TICKS(8)) dut1 (
      .clk(clk), .reset_n(b_rst_n), .enable(b_en),
      .read_addr(b_ra), .read_en(b_re),
      .read_data_top(b_top), .read_data_bottom(b_bot),
      .hub75_clk(b_clk), .hub75_lat(b_lat), .hub75_oe_n(b_oe_n), .hub75_addr(b_addr),
      .hub75_r1(b_r1), .hub75_g1(b_g1), .hub75_b1(b_b1),
      .hub75_r2(b_r2), .hub75_g2(b_g2), .hub75_b2(b_b2),
      .frame_done(b_fd)
   );

   task automatic test_reset();
      logic [14:0] obs;
      a_rst_n = 1'b0;
      a_en    = 1'b0;
      repeat (5) @(negedge clk);
      obs = {a_oe_n, a_lat, a_re, a_ra, a_fd, a_clk};
      n_checks++;
      if (obs !== 15'b1_0_0_0000000000_0_0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected %b", obs, 15'b100000000000000);
      end
      n_checks++;
      if ({a_addr, a_r1, a_g1, a_b1, a_r2, a_g2, a_b2} !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_pix: got %b expected 0", {a_addr, a_r1, a_g1, a_b1, a_r2, a_g2, a_b2});
      end
      a_rst_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         obs = {a_oe_n, a_lat, a_re, a_ra, a_fd, a_clk};
         n_checks++;
         if (obs !== 15'b1_0_0_0000000000_0_0) begin
            n_fail++;
            $display("FAIL idle_hold cycle %0d: got %b expected %b", i, obs, 15'b100000000000000);
         end
      end
   endtask

   task automatic test_scan();
      int cyc = 0, t0 = -1, last_fd = 0, fd_seen = 0, rises = 0;
      int oe_w = 0, exp_plane = 0, burst = 0, distinct = 0;
      logic [3:0] exp_row = 4'd0, win_addr = 4'd0;
      logic prev_clk = 1'b0, prev_oe = 1'b1, prev_re = 1'b0, prev_fd = 1'b0;
      logic addr_stable = 1'b1, ra_ok = 1'b1;
      logic [9:0] prev_ra = '0;
      a_en = 1'b1;
      while (fd_seen < 2 && cyc < 32000) begin
         @(negedge clk);
         cyc++;
         if (a_re && t0 < 0) t0 = cyc;
         if (a_clk && !prev_clk) begin
            rises++;
            n_checks++;
            if ({a_r1, a_g1, a_b1, a_r2, a_g2, a_b2} !== 6'b100001) begin
               n_fail++;
               $display("FAIL pix_const row %0d plane %0d: got %b expected 100001", exp_row, exp_plane,
                        {a_r1, a_g1, a_b1, a_r2, a_g2, a_b2});
            end
         end
         if (a_lat) begin
            n_checks++;
            if (rises != 64) begin
               n_fail++;
               $display("FAIL rises_per_lat: got %0d expected 64", rises);
            end
            rises = 0;
         end
         if (!a_oe_n) begin
            if (prev_oe) begin
               win_addr    = a_addr;
               oe_w        = 0;
               addr_stable = 1'b1;
            end
            oe_w++;
            if (a_addr !== win_addr) addr_stable = 1'b0;
            n_checks++;
            if ({a_re, a_clk, a_lat} !== 3'b000) begin
               n_fail++;
               $display("FAIL no_overlap: re/clk/lat got %b expected 000 while oe_n low", {a_re, a_clk, a_lat});
            end
         end else if (!prev_oe) begin
            n_checks++;
            if (oe_w != (8 << exp_plane)) begin
               n_fail++;
               $display("FAIL oe_width row %0d plane %0d: got %0d expected %0d", exp_row, exp_plane, oe_w, 8 << exp_plane);
            end
            n_checks++;
            if (!addr_stable || win_addr !== exp_row) begin
               n_fail++;
               $display("FAIL row_addr: got %0d (stable %b) expected %0d", win_addr, addr_stable, exp_row);
            end
            if (exp_plane == 4) begin
               exp_plane = 0;
               exp_row   = exp_row + 4'd1;
            end else begin
               exp_plane++;
            end
         end
         if (a_re) begin
            if (!prev_re) begin
               n_checks++;
               if (a_ra !== {exp_row, 6'd0}) begin
                  n_fail++;
                  $display("FAIL ra_first: got %h expected %h", a_ra, {exp_row, 6'd0});
               end
               burst    = 1;
               distinct = 1;
               ra_ok    = 1'b1;
            end else begin
               burst++;
               if (a_ra !== prev_ra) begin
                  distinct++;
                  if (a_ra !== prev_ra + 10'd1 || a_ra[9:6] !== exp_row) ra_ok = 1'b0;
               end
            end
         end else if (prev_re) begin
            n_checks++;
            if (!ra_ok || burst != 129 || distinct != 64 || prev_ra !== {exp_row, 6'd63}) begin
               n_fail++;
               $display("FAIL read_seq row %0d: ok %b len %0d distinct %0d last %h expected ok 1 len 129 distinct 64 last %h",
                        exp_row, ra_ok, burst, distinct, prev_ra, {exp_row, 6'd63});
            end
         end
         if (prev_fd) begin
            n_checks++;
            if (a_fd !== 1'b0) begin
               n_fail++;
               $display("FAIL frame_done_width: got %b expected 0", a_fd);
            end
         end
         if (a_fd) begin
            fd_seen++;
            n_checks++;
            if (fd_seen == 1 && cyc - t0 != 14448) begin
               n_fail++;
               $display("FAIL frame_first: got %0d expected 14448", cyc - t0);
            end else if (fd_seen == 2 && cyc - last_fd != 14448) begin
               n_fail++;
               $display("FAIL frame_period: got %0d expected 14448", cyc - last_fd);
            end
            last_fd = cyc;
         end
         prev_clk = a_clk;
         prev_oe  = a_oe_n;
         prev_re  = a_re;
         prev_ra  = a_ra;
         prev_fd  = a_fd;
      end
      n_checks++;
      if (fd_seen != 2) begin
         n_fail++;
         $display("FAIL frame_done_count: got %0d expected 2 within budget", fd_seen);
      end
   endtask

   task automatic test_reset_mid_shift();
      int cyc = 0;
      while (a_clk !== 1'b1 && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      n_checks++;
      if (a_clk !== 1'b1) begin
         n_fail++;
         $display("FAIL find_shift: hub75_clk got %b expected 1", a_clk);
      end
      a_rst_n = 1'b0;
      #1;
      n_checks++;
      if ({a_oe_n, a_clk, a_re, a_lat, a_ra} !== {4'b1000, 10'd0}) begin
         n_fail++;
         $display("FAIL async_reset: got %b expected %b", {a_oe_n, a_clk, a_re, a_lat, a_ra}, {4'b1000, 10'd0});
      end
      repeat (3) @(negedge clk);
      a_rst_n = 1'b1;
   endtask

   task automatic test_abort();
      int cyc = 0, wins = 0, w = 0;
      logic prev = 1'b1, done = 1'b0, first_ok = 1'b0;
      logic [3:0] wa = 4'd0;
      a_en = 1'b1;
      while (wins < 37 && cyc < 8000) begin
         @(negedge clk);
         cyc++;
         if (a_oe_n && !prev) wins++;
         prev = a_oe_n;
      end
      n_checks++;
      if (wins != 37) begin
         n_fail++;
         $display("FAIL abort_reach: got %0d windows expected 37", wins);
      end
      a_en = 1'b0;
      cyc  = 0;
      prev = 1'b1;
      while (!done && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (!a_oe_n) begin
            w++;
            wa = a_addr;
         end else if (!prev) begin
            done = 1'b1;
         end
         prev = a_oe_n;
      end
      n_checks++;
      if (!done || w != 32 || wa !== 4'd7) begin
         n_fail++;
         $display("FAIL abort_display: done %b width %0d row %0d expected done 1 width 32 row 7", done, w, wa);
      end
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         n_checks++;
         if ({a_oe_n, a_re, a_lat, a_fd} !== 4'b1000) begin
            n_fail++;
            $display("FAIL idle_after_abort cycle %0d: got %b expected 1000", i, {a_oe_n, a_re, a_lat, a_fd});
         end
      end
      a_en = 1'b1;
      cyc  = 0;
      while (a_lat !== 1'b1 && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (a_re && !first_ok && a_ra === 10'd0) first_ok = 1'b1;
      end
      n_checks++;
      if (a_lat !== 1'b1 || a_addr !== 4'd0 || !first_ok) begin
         n_fail++;
         $display("FAIL restart_row: lat %b addr %0d first_read_zero %b expected 1 0 1", a_lat, a_addr, first_ok);
      end
      w    = 0;
      done = 1'b0;
      prev = 1'b1;
      cyc  = 0;
      while (!done && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (!a_oe_n) w++;
         else if (!prev) done = 1'b1;
         prev = a_oe_n;
      end
      n_checks++;
      if (!done || w != 8) begin
         n_fail++;
         $display("FAIL restart_plane: width %0d expected 8", w);
      end
      a_en = 1'b0;
   endtask

   task automatic test_single_pixel();
      int cyc = 0, t0 = -1, rises = 0, nl = 0, hits = 0;
      logic prev_clk = 1'b0, fd_seen = 1'b0, hit;
      logic [5:0] exp_pix;
      b_rst_n = 1'b1;
      b_en    = 1'b1;
      while (!fd_seen && cyc < 2600) begin
         @(negedge clk);
         cyc++;
         if (b_re && t0 < 0) t0 = cyc;
         if (b_clk && !prev_clk) begin
            hit     = ((nl % 16) == 3) && (rises == 5);
            exp_pix = hit ? 6'b111000 : 6'b000000;
            if (hit) hits++;
            n_checks++;
            if ({b_r1, b_g1, b_b1, b_r2, b_g2, b_b2} !== exp_pix) begin
               n_fail++;
               $display("FAIL pixel row %0d col %0d: got %b expected %b", nl % 16, rises,
                        {b_r1, b_g1, b_b1, b_r2, b_g2, b_b2}, exp_pix);
            end
            rises++;
         end
         if (b_lat) begin
            n_checks++;
            if (b_addr !== 4'(nl % 16)) begin
               n_fail++;
               $display("FAIL b_row_addr: got %0d expected %0d", b_addr, nl % 16);
            end
            rises = 0;
            nl++;
         end
         if (b_fd) fd_seen = 1'b1;
         prev_clk = b_clk;
      end
      n_checks++;
      if (!fd_seen || cyc - t0 != 2224 || hits != 1 || nl != 16) begin
         n_fail++;
         $display("FAIL b_frame: seen %b period %0d hits %0d lats %0d expected 1 2224 1 16", fd_seen, cyc - t0, hits, nl);
      end
   endtask

   initial begin
      a_rst_n = 1'b0;
      a_en    = 1'b0;
      b_rst_n = 1'b0;
      b_en    = 1'b0;
      test_reset();
      test_scan();
      test_reset_mid_shift();
      test_abort();
      test_single_pixel();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/hub75_scan_driver.md
Name: hub75_scan_driver

Overview:
- Downstream consumer of the double-buffered frame RAM read port.
- Walks the display-side buffer row by row and issues read_addr/read_en; the RAM returns top-half and bottom-half pixels together.
- Converts each RGB565 pair into binary-coded-modulation (BCM) bit-planes and drives a 64x32, 1/16-scan HUB75 panel.
- Pulses frame_done once per complete frame so the writer side can flip buffer_toggle at a safe boundary.

Parameters:
- BPP, 5, bit-planes per colour, 1..5; uses the MSBs of each colour field.
- BASE_TICKS, 8, clk cycles that plane 0 is displayed; plane p is displayed for BASE_TICKS<<p.

Ports:
- clk  in  1  system clock, shared with the RAM read_clk.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  run the scan; when low, the driver idles blanked.
- read_addr  out  10  RAM read address {row[3:0], col[5:0]}.
- read_en  out  1  RAM read enable.
- read_data_top  in  16  RGB565 pixel for rows 0-15; valid 1 cycle after its address with read_en high.
- read_data_bottom  in  16  RGB565 pixel for rows 16-31; same timing as read_data_top.
- hub75_clk  out  1  panel shift clock.
- hub75_lat  out  1  panel latch.
- hub75_oe_n  out  1  panel output enable, active low.
- hub75_addr  out  4  panel row select A-D.
- hub75_r1, hub75_g1, hub75_b1  out  1 each  top-half colour bits.
- hub75_r2, hub75_g2, hub75_b2  out  1 each  bottom-half colour bits.
- frame_done  out  1  single-cycle pulse at the end of each frame.

Behaviour:
- Reset (asynchronous, reset_n=0): hub75_oe_n=1; every other output 0; FSM in IDLE; row=0, plane=0, col=0.
- FSM states: IDLE, PREFETCH, SHIFT_LO, SHIFT_HI, BLANK, LATCH, DISPLAY.
- IDLE: oe_n=1, read_en=0. Moves to PREFETCH with row=0, plane=0 when enable=1.
- PREFETCH (1 cycle):
  - read_en=1, read_addr={row,0}.
  - read_en stays high from PREFETCH through the last SHIFT_HI, and is 0 in every other state.
- SHIFT_LO/SHIFT_HI (alternate, 2 cycles per column, 64 columns = 128 cycles):
  - hub75_clk=0 in SHIFT_LO and 1 in SHIFT_HI.
  - Colour outputs are registered and change only on the edge entering SHIFT_LO. They are stable across the hub75_clk rising edge.
  - Column c is driven in the c-th SHIFT_LO/SHIFT_HI pair.
  - read_addr advances to {row,c+1} so the 1-cycle RAM latency is hidden. read_addr never exceeds {row,63} within a row pass.
- Bit mapping for plane p, with k=p+5-BPP:
  - r = data[11+k]
  - g = data[5+k+1]
  - b = data[k]
  - Top-half data feeds r1/g1/b1; bottom-half data feeds r2/g2/b2.
- oe_n=1 throughout PREFETCH, SHIFT, BLANK and LATCH. No display overlap with shifting.
- BLANK (1 cycle): hub75_clk=0; hub75_addr updates to row.
- LATCH (1 cycle): hub75_lat=1; it is 0 in every other state.
- DISPLAY:
  - oe_n=0 for exactly BASE_TICKS<<plane cycles.
  - Then: if plane<BPP-1, plane++ and go to PREFETCH with the same row.
  - Otherwise plane=0 and row++ (modulo 16).
  - When row wraps 15->0, frame_done=1 for the cycle after the final DISPLAY cycle.
  - Next state is PREFETCH if enable=1, else IDLE.
- Cycles per row-plane: 131 + (BASE_TICKS<<plane).
  - Frame period = 16*(131*BPP + BASE_TICKS*(2^BPP - 1)).
  - Defaults: 16*(655+248) = 14448 cycles.
- enable deasserted mid-frame: the current row-plane (shift, latch and full display time) completes, then IDLE.
  - Re-enable restarts at row 0, plane 0.
  - No frame_done is issued for the aborted frame.
- Reset mid-operation: outputs return to reset values immediately (asynchronous). The next scan starts at row 0, plane 0.
- Row and column counters wrap modulo 16 and 64; no out-of-range addresses are ever issued.

Test Plan:
- Reset with enable=0 -> oe_n=1, lat=0, read_en=0, addr=0 held indefinitely; no frame_done.
- RAM model top=16'hF800, bottom=16'h001F at all addresses, BPP=5, BASE_TICKS=8 -> r1=1, g1=b1=0, b2=1, r2=g2=0 on every rising hub75_clk. Exactly 64 hub75_clk rises between consecutive lat pulses.
- Same run, measure oe_n-low widths -> 8, 16, 32, 64, 128 cycles in order per row. hub75_addr is constant during each window and steps 0..15.
- Continuous enable -> frame_done pulses exactly 14448 cycles apart, each 1 cycle wide. read_addr sequence per plane is {row,0}..{row,63}.
- Pixel value 16'h8410 at address {3,5} only, BPP=1 -> r1, g1, b1 are all 1 only on column 5 of row 3. Everything else is 0.
- Drop enable during plane 2 of row 7 -> that DISPLAY completes (32 cycles), then IDLE with oe_n=1. Re-enable -> first hub75_addr latched is 0. Asserting reset_n=0 mid-SHIFT forces oe_n=1 and hub75_clk=0 immediately.
